pipe_reg_sf: RTL and testbench



---
 rtl/pipe_reg_sf.sv | 69 ++++++
 tb/tb_pipe_reg_sf.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_sf.sv
// Parametrised pipeline stage register with stall, flush, per-stage valid,
// registered occupancy and a saturating stall-cycle counter.
module pipe_reg_sf #(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 1,
  parameter logic [WIDTH-1:0] NOP   = '0,
  localparam int              OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             vi,
  input  logic [WIDTH-1:0] di,
  output logic             vo,
  output logic [WIDTH-1:0] dout,
  output logic [OCC_W-1:0] occ,
  output logic [15:0]      stall_cnt
);

  // Valid semantics: vi qualifies di on an advancing edge (en=1, flush=0);
  // there is no back-pressure, the hazard unit stalls via en. vo qualifies
  // dout every cycle. The output data port is named dout because "do" is a
  // reserved word.

  logic [WIDTH-1:0] d_q    [DEPTH];
  logic [WIDTH-1:0] d_next [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_next;
  logic [OCC_W-1:0] occ_next;

  always_comb begin
    d_next   = d_q;
    v_next   = v_q;
    occ_next = '0;
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) d_next[k] = NOP;
      v_next = '0;
    end else if (en) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        d_next[k] = d_q[k-1];
        v_next[k] = v_q[k-1];
      end
      v_next[0] = vi;
      // Invalid inputs are replaced by NOP so stale data never travels down.
      d_next[0] = vi ? di : NOP;
    end
    for (int k = 0; k < DEPTH; k++) occ_next = occ_next + OCC_W'(v_next[k]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) d_q[k] <= NOP;
      v_q       <= '0;
      occ       <= '0;
      stall_cnt <= '0;
    end else begin
      d_q <= d_next;
      v_q <= v_next;
      occ <= occ_next;
      // A flush coinciding with a stall is not counted as a stalled cycle.
      if (!flush && !en && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign vo   = v_q[DEPTH-1];
  assign dout = d_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_sf.sv
// Bench for pipe_reg_sf: three instances (DEPTH 3/1/8) share one randomized
// stimulus stream and are checked against a history-of-advances model.
module tb_pipe_reg_sf;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
  } slot_t;

  localparam int DEP [3] = '{3, 1, 8};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        flush = 1'b0;
  logic        vi    = 1'b0;
  logic [31:0] di    = '0;

  logic        vo_a  [3];
  logic [31:0] do_a  [3];
  logic [3:0]  occ_a [3];
  logic [15:0] st_a  [3];

  logic [31:0] dout0;
  logic [7:0]  dout1, dout2;
  logic [1:0]  occ0;
  logic [0:0]  occ1;
  logic [3:0]  occ2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_reg_sf #(.WIDTH(32), .DEPTH(3), .NOP(32'h0000_0000)) u_d3 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .vi(vi), .di(di),
    .vo(vo_a[0]), .dout(dout0), .occ(occ0), .stall_cnt(st_a[0]));

  pipe_reg_sf #(.WIDTH(8), .DEPTH(1), .NOP(8'h3C)) u_d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .vi(vi), .di(di[7:0]),
    .vo(vo_a[1]), .dout(dout1), .occ(occ1), .stall_cnt(st_a[1]));

  pipe_reg_sf #(.WIDTH(8), .DEPTH(8), .NOP(8'h3C)) u_d8 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .vi(vi), .di(di[7:0]),
    .vo(vo_a[2]), .dout(dout2), .occ(occ2), .stall_cnt(st_a[2]));

  assign do_a[0]  = dout0;
  assign do_a[1]  = {24'h0, dout1};
  assign do_a[2]  = {24'h0, dout2};
  assign occ_a[0] = {2'b0, occ0};
  assign occ_a[1] = {3'b0, occ1};
  assign occ_a[2] = occ2;

  function automatic logic [31:0] nop_of(input int i);
    return (i == 0) ? 32'h0000_0000 : 32'h0000_003C;
  endfunction

  function automatic logic [31:0] mask_of(input int i);
    return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 25)
        $display("FAIL %s[%0d] @%0t: got %h expected %h", name, idx, $time, act, exp);
    end
  endtask

  // Reference model: every advancing edge since the last reset/flush adds one
  // slot; the output of a DEPTH-d pipe is the slot added d advances ago.
  slot_t       hist [$];
  logic [31:0] exp_q [3][$];
  logic [31:0] last [3];
  logic [15:0] exp_stall = '0;
  bit          started = 0;
  bit          fresh = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      hist.delete();
      for (int i = 0; i < 3; i++) exp_q[i].delete();
      exp_stall = '0;
      started = 1;
      fresh = 0;
    end else if (flush) begin
      hist.delete();
      for (int i = 0; i < 3; i++) exp_q[i].delete();
      fresh = 0;
    end else if (en) begin
      hist.push_back({vi, di});
      while (hist.size() > 8) void'(hist.pop_front());
      if (vi) for (int i = 0; i < 3; i++) exp_q[i].push_back(di & mask_of(i));
      fresh = 1;
    end else begin
      if (exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      fresh = 0;
    end
  end

  // Monitor: cycle-level checks of vo/occ/stall_cnt plus scoreboard pops of
  // each newly presented valid item.
  always @(negedge clk) begin
    int          d, n, eo, lo;
    slot_t       s;
    logic [31:0] e;
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        d  = DEP[i];
        n  = hist.size();
        s  = (n >= d) ? hist[n-d] : '0;
        lo = (n >= d) ? n - d : 0;
        eo = 0;
        for (int k = lo; k < n; k++) eo += int'(hist[k].v);
        chk("stall_cnt", i, {16'h0, st_a[i]}, {16'h0, exp_stall});
        chk("vo", i, {31'h0, vo_a[i]}, {31'h0, s.v});
        chk("occ", i, {28'h0, occ_a[i]}, eo);
        if (!s.v) chk("do_nop", i, do_a[i], nop_of(i));
        if (vo_a[i] && fresh) begin
          if (exp_q[i].size() == 0) begin
            chk("sb_underflow", i, 32'd0, 32'd1);
          end else begin
            e = exp_q[i].pop_front();
            chk("do_sb", i, do_a[i], e);
            last[i] = e;
          end
        end else if (vo_a[i]) begin
          chk("do_hold", i, do_a[i], last[i]);
        end
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic f, input logic v,
                      input logic [31:0] x);
    rst_n = r; en = e; flush = f; vi = v; di = x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) last[i] = '0;
    // Reset with live-looking inputs.
    step(0, 1, 0, 1, 32'hDEAD_BEEF);
    step(0, 1, 0, 1, 32'hDEAD_BEEF);
    chk("rst_do", 0, do_a[0], 32'h0);
    chk("rst_do", 2, do_a[2], 32'h3C);
    chk("rst_occ", 0, {28'h0, occ_a[0]}, 32'd0);
    chk("rst_stall", 0, {16'h0, st_a[0]}, 32'd0);

    // Stream, stall 4 cycles mid-stream, resume.
    step(1, 1, 0, 1, 32'h1111_1111);
    step(1, 1, 0, 1, 32'h2222_2222);
    step(1, 1, 0, 1, 32'h3333_3333);
    chk("lat_d3", 0, do_a[0], 32'h1111_1111);
    chk("occ_full", 0, {28'h0, occ_a[0]}, 32'd3);
    step(1, 1, 0, 1, 32'h4444_4444);
    repeat (4) step(1, 0, 0, 1, $urandom);
    chk("stall_plus4", 0, {16'h0, st_a[0]}, 32'd4);
    for (int k = 5; k <= 9; k++) step(1, 1, 0, 1, {8{k[3:0]}});

    // Flush while full and stalled.
    chk("pre_flush_occ", 0, {28'h0, occ_a[0]}, 32'd3);
    step(1, 0, 1, 1, $urandom);
    chk("flush_occ", 0, {28'h0, occ_a[0]}, 32'd0);
    chk("flush_do", 2, do_a[2], 32'h3C);
    chk("flush_stall", 0, {16'h0, st_a[0]}, 32'd4);
    step(1, 1, 0, 1, 32'hA5A5_A5A5);
    repeat (9) step(1, 1, 0, 0, $urandom);

    // Bubble between two valid items.
    step(1, 1, 0, 1, 32'h1234_5678);
    step(1, 1, 0, 0, 32'hFFFF_FFFF);
    step(1, 1, 0, 1, 32'h8765_4321);
    chk("bubble_occ", 0, {28'h0, occ_a[0]}, 32'd2);
    repeat (9) step(1, 1, 0, 0, $urandom);

    // Randomized mix of advance, stall, flush, bubbles and occasional reset.
    repeat (600)
      step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
           ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
           $urandom);

    // A glitch on rst_n between edges must be ignored.
    step(1, 1, 0, 1, 32'hC0DE_0001);
    step(1, 1, 0, 1, 32'hC0DE_0002);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step(1, 1, 0, 1, 32'hC0DE_0003);
    chk("glitch_occ", 0, {28'h0, occ_a[0]}, 32'd3);

    // Saturation of the stall counter, then reset clears it.
    repeat (70000) step(1, 0, 0, $urandom_range(0, 1), $urandom);
    chk("stall_sat", 0, {16'h0, st_a[0]}, 32'h0000_FFFF);
    chk("stall_sat", 2, {16'h0, st_a[2]}, 32'h0000_FFFF);
    step(0, 0, 0, 1, $urandom);
    chk("stall_clr", 0, {16'h0, st_a[0]}, 32'd0);
    chk("rst_mid_vo", 0, {31'h0, vo_a[0]}, 32'd0);
    repeat (10) step(1, 1, 0, 1, $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
